sti_dac_gen: RTL
================

Name: sti_dac_gen

Overview:
- Parametrised successor of the team's serial-transmit-interface / DAC-writer block.
- Captures a parallel word with framing controls and shifts it out serially as a frame of configurable length.
- Packs the same serial stream into PIX_W-bit pixels written sequentially into a pixel memory.
- Adds a load handshake (pi_ready), continuous bit packing across frames, partial-pixel flush and zero-fill of the remaining memory at end of stream.

Parameters:
- DATA_W, 16, parallel input width; even, and DATA_W/2 a multiple of PIX_W.
- PIX_W, 8, pixel word width.
- NUM_PIX, 256, pixel memory depth; power of two.
- ADDR_W, log2(NUM_PIX)=8, pixel address width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- load  in  1  frame request; accepted only when pi_ready=1.
- pi_data  in  DATA_W  parallel data.
- pi_length  in  2  frame length code; frame length L=(code+1)*DATA_W/2 bits.
- pi_fill  in  1  when L>DATA_W: 1 = data at frame MSBs with zero LSBs; 0 = data at LSBs with zero MSBs.
- pi_msb  in  1  1 = frame sent MSB first; 0 = LSB first.
- pi_low  in  1  code 0 only: 1 = send pi_data[DATA_W/2-1:0]; 0 = send the upper half.
- pi_end  in  1  marks the accepted frame as the last one.
- pi_ready  out  1  idle and able to accept load.
- so_data  out  1  serial bit.
- so_valid  out  1  so_data valid.
- pixel_wr  out  1  pixel write strobe.
- pixel_addr  out  ADDR_W  write address.
- pixel_dataout  out  PIX_W  write data.
- pixel_finish  out  1  memory complete.

Behaviour:
- Reset (async, reset=0): state IDLE; pi_ready=1; all other outputs 0; bit counter, pack register and pack count cleared.
- States: IDLE -> SHIFT -> (IDLE | FLUSH | FILL | DONE).
- IDLE:
  - pi_ready=1.
  - Edge with load=1: capture pi_data and all controls, build the frame, enter SHIFT. All inputs are don't-care thereafter.
  - load while pi_ready=0 is ignored.
- Frame build (FRAME_W=2*DATA_W bits, L bits used):
  - code 0: selected half.
  - code 1: pi_data.
  - codes 2/3: pi_fill places pi_data at the top or bottom of L; the remainder is zero.
- SHIFT:
  - so_valid=1 for exactly L consecutive cycles, starting the cycle after capture.
  - One bit per cycle, in the order set by pi_msb.
  - so_data=0 whenever so_valid=0.
- Packing:
  - Each transmitted bit shifts into the pack register at the LSB end, so the first bit received lands at the pixel MSB.
  - Packing is continuous across frames; the pack count carries over.
  - When the PIX_W-th bit is taken, pixel_wr pulses for 1 cycle the following cycle, with pixel_dataout=word and the current pixel_addr.
  - pixel_addr increments after each write and wraps NUM_PIX-1 -> 0 silently.
- After the last bit:
  - pi_end=0: return to IDLE; pi_ready=1 one cycle after the last so_valid.
  - pi_end=1 with a partial pixel pending: FLUSH writes it left-aligned, zero-padded in its LSBs (one pixel_wr).
  - pi_end=1, then FILL: write 0 to every remaining address up to NUM_PIX-1, one write per cycle, consecutive.
  - If the last write already hit NUM_PIX-1, skip FILL.
- DONE:
  - pixel_finish=1 starting the cycle after the final write, held until reset.
  - pi_ready=0; so_valid=0; pixel_wr=0.
- Simultaneous events: pixel_wr may coincide with so_valid of the same or the next frame. Writes never stall the shifter.
- Reset mid-frame or mid-FILL: immediate return to reset values; the partial pixel is discarded and pixel_addr restarts at 0.

Test Plan:
- DATA_W=16, pi_data=16'h1234, code 1, pi_msb=0 -> so_data 0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0 over 16 cycles; pixel_wr addr0=8'h2C, addr1=8'h48; pi_ready high the cycle after the last bit.
- pi_data=16'hA5C3, code 0, pi_msb=1: pi_low=1 -> bits of 8'hC3, pixel 8'hC3; pi_low=0 next frame -> pixel 8'hA5 at addr+1.
- pi_data=16'hBEEF, code 3, pi_fill=1, pi_msb=1 -> 32 so_valid cycles, pixels BE,EF,00,00.
- pi_data=16'hBEEF, code 3, pi_fill=0 -> pixels 00,00,BE,EF.
- Single frame, code 0, pi_end=1, pi_data=16'h00FF, pi_low=1 -> addr0=FF; then addrs 1..255 written 0 in 255 consecutive cycles; pixel_finish=1 the cycle after the write to 255 and held; a later load is ignored.
- Reset pulsed low during bit 5 of a code 2 frame -> so_valid, pixel_wr, pixel_addr 0 immediately; after release pi_ready=1 and a new frame writes from addr0.
- Bit-ordering check for mis-accepted loads: load asserted while pi_ready=0 during SHIFT -> no effect on the bit count or data.

Source files
------------

// File: rtl/sti_dac_gen.sv
// sti_dac_gen: frames a parallel word into a serial stream and packs that stream into sequential pixel-memory writes.
module sti_dac_gen #(
    parameter int DATA_W  = 16,
    parameter int PIX_W   = 8,
    parameter int NUM_PIX = 256,
    parameter int ADDR_W  = $clog2(NUM_PIX)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] pi_data,
    input  logic [1:0]        pi_length,
    input  logic              pi_fill,
    input  logic              pi_msb,
    input  logic              pi_low,
    input  logic              pi_end,
    output logic              pi_ready,
    output logic              so_data,
    output logic              so_valid,
    output logic              pixel_wr,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [PIX_W-1:0]  pixel_dataout,
    output logic              pixel_finish
);
    localparam int HALF    = DATA_W / 2;
    localparam int FRAME_W = 2 * DATA_W;
    localparam int CW      = $clog2(FRAME_W);
    localparam int PCW     = $clog2(PIX_W);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIX - 1);

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_FLUSH, S_FILL, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [FRAME_W-1:0] r_frame, w_frame;
    logic [CW-1:0]      r_idx, r_cnt, w_last;
    logic               r_msb, r_end, r_wr, w_bit;
    logic [PIX_W-1:0]   r_pack, r_wdata, w_word;
    logic [PCW-1:0]     r_pcnt, w_pcnt_nxt;
    logic [ADDR_W-1:0]  r_addr;

    // The frame occupies bits [L-1:0]; r_idx walks it in either direction.
    always_comb begin
        w_last     = CW'((int'(pi_length) + 1) * HALF - 1);
        w_frame    = (pi_length == 2'd0) ? FRAME_W'(pi_low ? pi_data[HALF-1:0] : pi_data[DATA_W-1:HALF])
                   : (pi_fill && pi_length[1]) ? FRAME_W'(pi_data) << ((int'(pi_length) - 1) * HALF)
                   : FRAME_W'(pi_data);
        w_bit      = r_frame[r_idx];
        w_pcnt_nxt = (r_pcnt == PCW'(PIX_W - 1)) ? '0 : r_pcnt + 1'b1;
        w_word     = {r_pack[PIX_W-2:0], w_bit};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = load ? S_SHIFT : S_IDLE;
            S_SHIFT: w_next = (r_cnt != '0) ? S_SHIFT : !r_end ? S_IDLE
                            : (w_pcnt_nxt != '0) ? S_FLUSH : S_FILL;
            S_FLUSH: w_next = S_FILL;
            S_FILL:  w_next = (r_addr == LAST) ? S_DONE : S_FILL;
            default: w_next = S_DONE;
        endcase
    end

    always_comb begin
        pi_ready      = r_state == S_IDLE;
        so_valid      = r_state == S_SHIFT;
        so_data       = (r_state == S_SHIFT) && w_bit;
        pixel_finish  = r_state == S_DONE;
        pixel_wr      = r_wr;
        pixel_addr    = r_addr;
        pixel_dataout = r_wdata;
    end

    // FILL always follows a write cycle, so each FILL cycle queues the next zero write until LAST.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_msb   <= 1'b0;
            r_end   <= 1'b0;
            r_pack  <= '0;
            r_pcnt  <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_addr  <= '0;
        end else begin
            if (r_state == S_IDLE && load) begin
                r_frame <= w_frame;
                r_cnt   <= w_last;
                r_idx   <= pi_msb ? w_last : '0;
                r_msb   <= pi_msb;
                r_end   <= pi_end;
            end
            if (r_state == S_SHIFT) begin
                r_idx  <= r_msb ? r_idx - 1'b1 : r_idx + 1'b1;
                r_cnt  <= r_cnt - 1'b1;
                r_pack <= w_word;
                r_pcnt <= w_pcnt_nxt;
            end
            if (r_state == S_FLUSH) r_pcnt <= '0;
            r_wr    <= (r_state == S_SHIFT) ? (w_pcnt_nxt == '0)
                     : (r_state == S_FLUSH) ? 1'b1
                     : (r_state == S_FILL) && (r_addr != LAST);
            r_wdata <= (r_state == S_SHIFT && w_pcnt_nxt == '0) ? w_word
                     : (r_state == S_FLUSH) ? r_pack << (PIX_W - int'(r_pcnt))
                     : (r_state == S_FILL) ? '0 : r_wdata;
            r_addr  <= r_addr + ADDR_W'(r_wr);
        end
    end
endmodule
